// File: rtl/xalu_muldiv_pkg.sv
// Shared definitions for the XALU multiply/divide unit: op codes, FSM states
// and small operand-conditioning helpers.
package xalu_muldiv_pkg;

  // XALU op codes presented on the op port
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Cycle counter width; covers the 33-cycle divide with margin
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL     = 2'd1,
    ST_DIV     = 2'd2,
    ST_DIV_FIX = 2'd3
  } state_t;

  // Magnitude of a 32-bit operand; signed ops take the absolute value
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      mag32 = 32'd0 - v;
    end else begin
      mag32 = v;
    end
  endfunction

  // 33-bit extension: sign bit for signed ops, zero for unsigned ops
  function automatic logic [32:0] ext33(input logic [31:0] v, input logic is_signed);
    ext33 = {is_signed & v[31], v};
  endfunction

endpackage

// File: rtl/xalu_div_iter.sv
// One radix-2 restoring divide step on magnitudes:
// shift {rem, quot} left one bit, trial-subtract the divisor, keep or restore.
module xalu_div_iter (
  input  logic [31:0] rem_i,
  input  logic [31:0] quot_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic [31:0] quot_o
);

  logic [32:0] part_s;
  logic [32:0] diff_s;

  // Trial subtraction; rem < divisor keeps the partial remainder below 2*divisor,
  // so bit 32 of the difference is a clean borrow flag.
  always_comb begin
    part_s = {rem_i, quot_i[31]};
    diff_s = part_s - {1'b0, dvs_i};
    if (!diff_s[32]) begin
      rem_o  = diff_s[31:0];
      quot_o = {quot_i[30:0], 1'b1};
    end else begin
      rem_o  = part_s[31:0];
      quot_o = {quot_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/xalu_muldiv.sv
// XALU multi-cycle multiply/divide unit. Owns HI/LO, runs mult/multu/mul over
// MUL_CYCLES cycles and div/divu as 32 restoring iterations plus a sign fixup.
module xalu_muldiv
  import xalu_muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_result,
  output logic        mul_valid
);

  // Last counter value in each busy phase
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 2);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [32:0]       opa_q, opa_d;       // captured rs_val, sign/zero extended
  logic [32:0]       opb_q, opb_d;       // captured rt_val, sign/zero extended
  logic              is_mul_q, is_mul_d; // MUL writes mul_result instead of HI/LO
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       quot_q, quot_d;
  logic [31:0]       dvs_q, dvs_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       mul_result_q, mul_result_d;
  logic              mul_valid_q, mul_valid_d;

  logic [63:0]       mul_a_s, mul_b_s, prod_s;
  logic [31:0]       rem_nx_s, quot_nx_s;
  logic              div_zero_s;
  logic              op_signed_s;

  xalu_div_iter u_div_iter (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .dvs_i  (dvs_q),
    .rem_o  (rem_nx_s),
    .quot_o (quot_nx_s)
  );

  // Behavioural 33x33 multiply of the captured operands; the multi-cycle MUL
  // state gives the product MUL_CYCLES cycles to settle. Extending to 64 bits
  // keeps the low 64 product bits exact for both signed and unsigned ops.
  always_comb begin
    mul_a_s = {{31{opa_q[32]}}, opa_q};
    mul_b_s = {{31{opb_q[32]}}, opb_q};
    prod_s  = mul_a_s * mul_b_s;
  end

  // Decode of the incoming op's signedness and divide-by-zero of the captured divisor
  always_comb begin
    op_signed_s = (op == OP_MULT) || (op == OP_MUL) || (op == OP_DIV);
    div_zero_s  = (opb_q[31:0] == 32'd0);
  end

  // Next-state and datapath update for the IDLE/MUL/DIV/DIV_FIX sequencer
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    is_mul_d     = is_mul_q;
    rem_d        = rem_q;
    quot_d       = quot_q;
    dvs_d        = dvs_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_result_d = mul_result_q;
    mul_valid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // start together with flush is dropped entirely
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU, OP_MUL: begin
              state_d  = ST_MUL;
              cnt_d    = '0;
              opa_d    = ext33(rs_val, op_signed_s);
              opb_d    = ext33(rt_val, op_signed_s);
              is_mul_d = (op == OP_MUL);
            end
            OP_DIV, OP_DIVU: begin
              state_d  = ST_DIV;
              cnt_d    = '0;
              opa_d    = ext33(rs_val, op_signed_s);
              opb_d    = ext33(rt_val, op_signed_s);
              is_mul_d = 1'b0;
              rem_d    = 32'd0;
              quot_d   = mag32(rs_val, op_signed_s);
              dvs_d    = mag32(rt_val, op_signed_s);
            end
            OP_MTHI: begin
              hi_d = rs_val;
            end
            OP_MTLO: begin
              lo_d = rs_val;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MUL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == MUL_LAST) begin
          state_d = ST_IDLE;
          if (is_mul_q) begin
            mul_result_d = prod_s[31:0];
            mul_valid_d  = 1'b1;
          end else begin
            hi_d = prod_s[63:32];
            lo_d = prod_s[31:0];
          end
        end else begin
          state_d = ST_MUL;
        end
      end

      ST_DIV: begin
        cnt_d  = cnt_q + CNT_W'(1);
        rem_d  = rem_nx_s;
        quot_d = quot_nx_s;
        if (cnt_q == DIV_LAST) begin
          state_d = ST_DIV_FIX;
        end else begin
          state_d = ST_DIV;
        end
      end

      ST_DIV_FIX: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_IDLE;
        if (div_zero_s) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = opa_q[31:0];
        end else begin
          // Quotient sign from both operands, remainder sign follows the dividend
          lo_d = (opa_q[32] ^ opb_q[32]) ? (32'd0 - quot_q) : quot_q;
          hi_d = opa_q[32] ? (32'd0 - rem_q) : rem_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; async reset drops any in-flight operation
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      opa_q        <= 33'd0;
      opb_q        <= 33'd0;
      is_mul_q     <= 1'b0;
      rem_q        <= 32'd0;
      quot_q       <= 32'd0;
      dvs_q        <= 32'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      mul_result_q <= 32'd0;
      mul_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      is_mul_q     <= is_mul_d;
      rem_q        <= rem_d;
      quot_q       <= quot_d;
      dvs_q        <= dvs_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_result_q <= mul_result_d;
      mul_valid_q  <= mul_valid_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign mul_result = mul_result_q;
  assign mul_valid  = mul_valid_q;

endmodule

// File: tb/tb_xalu_muldiv.sv
// Directed + small random bench for xalu_muldiv with a scoreboard queue of
// expected HI/LO/mul_result values.
module tb_xalu_muldiv;
  import xalu_muldiv_pkg::*;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mul_result;
  logic        mul_valid;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mr;
  } exp_t;

  exp_t        sb[$];
  int          total;
  int          passed;
  logic [31:0] m_hi, m_lo, m_mr;

  xalu_muldiv #(.MUL_CYCLES(4), .DIV_CYCLES(33)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .op         (op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .flush      (flush),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo),
    .mul_result (mul_result),
    .mul_valid  (mul_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle; returns just after the accept edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    chk("no_start_while_busy", {63'd0, busy}, 64'd0);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    flush  = fl;
    tick();
    start  = 1'b0;
    flush  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Issue an op, wait for completion, pop its expectation and compare
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic [31:0] emr, input int lat);
    exp_t e;
    int   n;
    e.hi = ehi; e.lo = elo; e.mr = emr;
    sb.push_back(e);
    issue(o, a, b, 1'b0);
    wait_done(0, n);
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    e = sb.pop_front();
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
    chk({tag, "_mul_result"}, {32'd0, mul_result}, {32'd0, e.mr});
    chk({tag, "_mul_valid"}, {63'd0, mul_valid}, {63'd0, (o == OP_MUL)});
    tick();
    chk({tag, "_mul_valid_drop"}, {63'd0, mul_valid}, 64'd0);
    m_hi = e.hi; m_lo = e.lo; m_mr = e.mr;
  endtask

  initial begin
    exp_t        e;
    int          n;
    logic [2:0]  ro;
    logic [31:0] ra, rb, ehi, elo;
    logic [63:0] p;
    int          sa, sbv;

    total = 0; passed = 0;
    m_hi = 32'd0; m_lo = 32'd0; m_mr = 32'd0;
    resetn = 1'b0; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; flush = 1'b0;
    tick(); tick();
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_mul_result", {32'd0, mul_result}, 64'd0);
    chk("reset_mul_valid", {63'd0, mul_valid}, 64'd0);
    resetn = 1'b1;
    tick();

    // MULTU max*max, stepped edge by edge
    e.hi = 32'hFFFF_FFFE; e.lo = 32'h0000_0001; e.mr = m_mr;
    sb.push_back(e);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_busy_e0", {63'd0, busy}, 64'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("multu_busy_mid", {63'd0, busy}, 64'd1);
    end
    chk("multu_lo_not_yet", {32'd0, lo}, 64'd0);
    tick();
    e = sb.pop_front();
    chk("multu_busy_e4", {63'd0, busy}, 64'd0);
    chk("multu_hi", {32'd0, hi}, {32'd0, e.hi});
    chk("multu_lo", {32'd0, lo}, {32'd0, e.lo});
    m_hi = e.hi; m_lo = e.lo;

    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, m_mr, 33);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, m_mr, 33);
    run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, m_mr, 33);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, m_mr, 33);
    run_op("div_m9_0", OP_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, m_mr, 33);
    run_op("mul", OP_MUL, 32'hFFFF_FFFE, 32'd3, m_hi, m_lo, 32'hFFFF_FFFA, 4);

    // MTHI / MTLO: single-edge, never busy
    issue(OP_MTHI, 32'h0000_1234, 32'd0, 1'b0);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    chk("mthi_hi", {32'd0, hi}, 64'h1234);
    chk("mthi_lo", {32'd0, lo}, {32'd0, m_lo});
    m_hi = 32'h0000_1234;
    issue(OP_MTLO, 32'h0000_5678, 32'd0, 1'b0);
    chk("mtlo_busy", {63'd0, busy}, 64'd0);
    chk("mtlo_lo", {32'd0, lo}, 64'h5678);
    chk("mtlo_hi", {32'd0, hi}, {32'd0, m_hi});
    m_lo = 32'h0000_5678;

    // start together with flush is dropped
    issue(OP_DIV, 32'd50, 32'd5, 1'b1);
    chk("startflush_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("startflush_busy2", {63'd0, busy}, 64'd0);
    chk("startflush_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("startflush_lo", {32'd0, lo}, {32'd0, m_lo});

    // flush during divide cycle 10 does not disturb the op
    e.hi = 32'd3; e.lo = 32'd100; e.mr = m_mr;
    sb.push_back(e);
    issue(OP_DIVU, 32'd1003, 32'd10, 1'b0);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done(10, n);
    chk("flushmid_latency", 64'(n), 64'd33);
    e = sb.pop_front();
    chk("flushmid_hi", {32'd0, hi}, {32'd0, e.hi});
    chk("flushmid_lo", {32'd0, lo}, {32'd0, e.lo});
    m_hi = e.hi; m_lo = e.lo;

    // Random ops against a reference model built on native arithmetic
    for (int k = 0; k < 6; k++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (k == 4) rb = rb >> 28;
      if (rb == 32'd0) rb = 32'd1;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      case (ro)
        OP_MULT: begin
          p = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
          ehi = p[63:32]; elo = p[31:0];
        end
        OP_MULTU: begin
          p = {32'd0, ra} * {32'd0, rb};
          ehi = p[63:32]; elo = p[31:0];
        end
        OP_DIV: begin
          sa = int'(ra); sbv = int'(rb);
          elo = 32'(sa / sbv); ehi = 32'(sa % sbv);
        end
        default: begin
          elo = ra / rb; ehi = ra % rb;
        end
      endcase
      run_op("rand", ro, ra, rb, ehi, elo, m_mr, (ro == OP_DIV || ro == OP_DIVU) ? 33 : 4);
    end

    // Async reset in the middle of a divide
    issue(OP_DIVU, 32'd12345, 32'd3, 1'b0);
    repeat (16) tick();
    chk("rstmid_busy_before", {63'd0, busy}, 64'd1);
    resetn = 1'b0;
    #1;
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    chk("rstmid_hi", {32'd0, hi}, 64'd0);
    chk("rstmid_lo", {32'd0, lo}, 64'd0);
    chk("rstmid_mul_result", {32'd0, mul_result}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0; m_mr = 32'd0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("rstmid_busy_after", {63'd0, busy}, 64'd0);
    run_op("mult_6_7", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, m_mr, 4);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
